// File: rtl/vel_accum_sat.sv
// Windowed velocity accumulator: sums the current sample with DEPTH past samples and clamps to
// [0, SAT_MAX]. Define VEL_SLEW_LIMIT_EN to limit each output step to +/-SLEW_STEP.
module vel_accum_sat #(
  parameter int IN_W      = 9,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 1,
  parameter int SAT_MAX   = 254,
  parameter int SLEW_STEP = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic signed [IN_W-1:0] in_vel,
  input  logic                   in_valid,
  input  logic                   clr,
  output logic [OUT_W-1:0]       out_vel,
  output logic                   out_valid,
  output logic                   ovf,
  output logic                   udf,
  output logic                   ovf_sticky,
  output logic                   primed
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // One extra bit beyond the growth of DEPTH+1 terms keeps the signed sum from wrapping.
  localparam int SUM_W = IN_W + CNT_W + 1;
  localparam logic signed [SUM_W-1:0] SatMaxS = SUM_W'(SAT_MAX);
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  logic signed [IN_W-1:0] hist_q [DEPTH];
  logic [CNT_W-1:0]       fill_q;
  logic [OUT_W-1:0]       out_vel_q;
  logic                   out_valid_q;
  logic                   ovf_q;
  logic                   udf_q;
  logic                   sticky_q;

  logic signed [SUM_W-1:0] sum_c;
  logic [OUT_W-1:0]        target_c;
  logic [OUT_W-1:0]        next_vel_c;
  logic                    ovf_c;
  logic                    udf_c;

  always_comb begin
    sum_c = {{(SUM_W-IN_W){in_vel[IN_W-1]}}, in_vel};
    for (int i = 0; i < DEPTH; i++) begin
      sum_c = sum_c + {{(SUM_W-IN_W){hist_q[i][IN_W-1]}}, hist_q[i]};
    end
  end

  always_comb begin
    target_c = '0;
    ovf_c    = 1'b0;
    udf_c    = 1'b0;
    if (sum_c[SUM_W-1]) begin
      udf_c = 1'b1;
    end else if (sum_c > SatMaxS) begin
      target_c = OUT_W'(SAT_MAX);
      ovf_c    = 1'b1;
    end else begin
      target_c = sum_c[OUT_W-1:0];
    end
  end

`ifdef VEL_SLEW_LIMIT_EN
  logic [OUT_W:0] step_w;
  logic [OUT_W:0] up_w;
  logic [OUT_W:0] diff_w;

  always_comb begin
    step_w     = (OUT_W+1)'(SLEW_STEP);
    up_w       = {1'b0, out_vel_q} + step_w;
    diff_w     = {1'b0, out_vel_q} - {1'b0, target_c};
    next_vel_c = target_c;
    if (target_c > out_vel_q) begin
      if ({1'b0, target_c} > up_w) next_vel_c = up_w[OUT_W-1:0];
    end else if (target_c < out_vel_q) begin
      if (diff_w > step_w) next_vel_c = out_vel_q - step_w[OUT_W-1:0];
    end
  end
`else
  always_comb begin
    next_vel_c = target_c;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_q      <= '0;
      out_vel_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      ovf_q       <= in_valid & ovf_c;
      udf_q       <= in_valid & udf_c;
      if (in_valid) begin
        hist_q[0] <= in_vel;
        for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        if (fill_q != DepthC) fill_q <= fill_q + 1'b1;
        out_vel_q <= next_vel_c;
        sticky_q  <= sticky_q | ovf_c | udf_c;
      end
    end
  end

  assign out_vel    = out_vel_q;
  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;
  assign ovf_sticky = sticky_q;
  assign primed     = (fill_q == DepthC);

endmodule

// File: tb/tb_vel_accum_sat.sv
// Directed bench for vel_accum_sat: a vector table on the default build plus a DEPTH=3 sequence.
module tb_vel_accum_sat;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // Default-parameter instance
  logic              a_rst_n, a_clr, a_valid;
  logic signed [8:0] a_vel;
  logic [7:0]        a_out;
  logic              a_ovalid, a_ovf, a_udf, a_sticky, a_primed;

  vel_accum_sat u_dut_a (
    .CLK       (CLK),
    .RST_N     (a_rst_n),
    .in_vel    (a_vel),
    .in_valid  (a_valid),
    .clr       (a_clr),
    .out_vel   (a_out),
    .out_valid (a_ovalid),
    .ovf       (a_ovf),
    .udf       (a_udf),
    .ovf_sticky(a_sticky),
    .primed    (a_primed)
  );

  // DEPTH=3 instance
  logic              b_rst_n, b_clr, b_valid;
  logic signed [8:0] b_vel;
  logic [7:0]        b_out;
  logic              b_ovalid, b_ovf, b_udf, b_sticky, b_primed;

  vel_accum_sat #(.DEPTH(3)) u_dut_b (
    .CLK       (CLK),
    .RST_N     (b_rst_n),
    .in_vel    (b_vel),
    .in_valid  (b_valid),
    .clr       (b_clr),
    .out_vel   (b_out),
    .out_valid (b_ovalid),
    .ovf       (b_ovf),
    .udf       (b_udf),
    .ovf_sticky(b_sticky),
    .primed    (b_primed)
  );

  typedef struct {
    bit rst_n;
    bit clr;
    bit valid;
    int vel;
    int e_vel;
    bit e_valid;
    bit e_ovf;
    bit e_udf;
    bit e_sticky;
    bit e_primed;
  } vec_t;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive_a(input bit rst_n, input bit clr, input bit valid, input int vel);
    @(negedge CLK);
    a_rst_n = rst_n;
    a_clr   = clr;
    a_valid = valid;
    a_vel   = 9'(vel);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_b(input bit rst_n, input bit clr, input bit valid, input int vel);
    @(negedge CLK);
    b_rst_n = rst_n;
    b_clr   = clr;
    b_valid = valid;
    b_vel   = 9'(vel);
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[$];
  int   b_exp_vel[12];
  bit   b_exp_ovf[12];
  bit   b_exp_udf[12];
  bit   b_exp_pri[12];
  int   b_in[12];

  initial begin
    a_rst_n = 1'b0; a_clr = 1'b0; a_valid = 1'b0; a_vel = '0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_valid = 1'b0; b_vel = '0;

    //            rst clr vld  vel   o_vel ov ovf udf stk pri
    vecs.push_back('{0, 0, 0,    0,    0, 0, 0, 0, 0, 0}); // reset
    vecs.push_back('{1, 0, 1,  100,  100, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 1,  100,  200, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 0,    0,  200, 0, 0, 0, 0, 1}); // hold
    vecs.push_back('{1, 1, 0,    0,    0, 0, 0, 0, 0, 0}); // clr
    vecs.push_back('{1, 0, 1,  200,  200, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 1,  100,  254, 1, 1, 0, 1, 1}); // 300 clamps
    vecs.push_back('{1, 0, 0,    0,  254, 0, 0, 0, 1, 1});
    vecs.push_back('{1, 0, 0,    0,  254, 0, 0, 0, 1, 1}); // sticky held
    vecs.push_back('{1, 1, 0,    0,    0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 1,  -50,    0, 1, 0, 1, 1, 1});
    vecs.push_back('{1, 0, 1,   20,    0, 1, 0, 1, 1, 1}); // -30
    vecs.push_back('{1, 1, 1,   77,    0, 0, 0, 0, 0, 0}); // clr discards sample
    vecs.push_back('{1, 0, 1,    5,    5, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 1,  250,  254, 1, 1, 0, 1, 1}); // 255 clamps
    vecs.push_back('{0, 0, 1,    9,    0, 0, 0, 0, 0, 0}); // reset discards sample
    vecs.push_back('{1, 0, 1,    5,    5, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 1,    0,    5, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 1,  254,  254, 1, 0, 0, 0, 1}); // exactly SAT_MAX
    vecs.push_back('{1, 0, 1, -256,    0, 1, 0, 1, 1, 1}); // -2
    vecs.push_back('{1, 0, 1,  255,    0, 1, 0, 1, 1, 1}); // -1
    vecs.push_back('{1, 0, 1,    0,  254, 1, 1, 0, 1, 1}); // 255
    vecs.push_back('{1, 0, 1,    1,  254, 1, 0, 0, 1, 1}); // 1+0 < SAT_MAX? no: 1
    vecs[$].e_vel = 1;
    vecs[$].e_ovf = 1'b0;

    foreach (vecs[i]) begin
      drive_a(vecs[i].rst_n, vecs[i].clr, vecs[i].valid, vecs[i].vel);
      chk("a_out_vel",   i, int'(a_out),    vecs[i].e_vel);
      chk("a_out_valid", i, int'(a_ovalid), int'(vecs[i].e_valid));
      chk("a_ovf",       i, int'(a_ovf),    int'(vecs[i].e_ovf));
      chk("a_udf",       i, int'(a_udf),    int'(vecs[i].e_udf));
      chk("a_sticky",    i, int'(a_sticky), int'(vecs[i].e_sticky));
      chk("a_primed",    i, int'(a_primed), int'(vecs[i].e_primed));
    end

    // DEPTH=3: fill, wide positive sums, wide negative sums, all back-to-back
    b_in      = '{10, 20, 30, 40, 255, 255, 255, 255, -256, -256, -256, -256};
    b_exp_vel = '{10, 30, 60, 100, 254, 254, 254, 254, 254, 0, 0, 0};
    b_exp_ovf = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    b_exp_udf = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    b_exp_pri = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    drive_b(1'b0, 1'b0, 1'b0, 0);
    chk("b_reset_vel",    0, int'(b_out),    0);
    chk("b_reset_primed", 0, int'(b_primed), 0);
    for (int i = 0; i < 12; i++) begin
      drive_b(1'b1, 1'b0, 1'b1, b_in[i]);
      chk("b_out_vel",   i, int'(b_out),    b_exp_vel[i]);
      chk("b_out_valid", i, int'(b_ovalid), 1);
      chk("b_ovf",       i, int'(b_ovf),    int'(b_exp_ovf[i]));
      chk("b_udf",       i, int'(b_udf),    int'(b_exp_udf[i]));
      chk("b_primed",    i, int'(b_primed), int'(b_exp_pri[i]));
    end
    chk("b_sticky", 0, int'(b_sticky), 1);

    // clr mid-stream with a sample present, then history must read as empty
    drive_b(1'b1, 1'b1, 1'b1, 99);
    chk("b_clr_valid",  0, int'(b_ovalid), 0);
    chk("b_clr_vel",    0, int'(b_out),    0);
    chk("b_clr_sticky", 0, int'(b_sticky), 0);
    chk("b_clr_primed", 0, int'(b_primed), 0);
    drive_b(1'b1, 1'b0, 1'b1, 5);
    chk("b_after_clr_vel", 0, int'(b_out), 5);
    drive_b(1'b1, 1'b0, 1'b1, 7);
    chk("b_after_clr_vel", 1, int'(b_out), 12);

    // reset mid-stream overrides the sample on that edge
    drive_b(1'b0, 1'b0, 1'b1, 50);
    chk("b_rst_valid",  0, int'(b_ovalid), 0);
    chk("b_rst_vel",    0, int'(b_out),    0);
    chk("b_rst_primed", 0, int'(b_primed), 0);
    drive_b(1'b1, 1'b0, 1'b1, 5);
    chk("b_after_rst_vel", 0, int'(b_out), 5);
    drive_b(1'b1, 1'b0, 0, 0);
    chk("b_idle_valid", 0, int'(b_ovalid), 0);
    chk("b_idle_vel",   0, int'(b_out),    5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
